// File: rtl/reg_reader_pkg.sv
// Shared definitions for the register-bank stream reader: FSM encodings and
// output buffer sizing.
package reg_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  // Saturating 16-bit increment used by the optional stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_skid_buf.sv
// Two-entry in-order buffer between the bank read port and the stream output.
// The head entry drives popData directly from a register.
module reg_skid_buf
  import reg_reader_pkg::*;
#(
  parameter int LEN = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [LEN-1:0]   pushData,
  output logic             popValid,
  output logic [LEN-1:0]   popData,
  input  logic             popReady,
  output logic [OCC_W-1:0] occupancy
);

  logic [LEN-1:0] head;
  logic [LEN-1:0] tail;
  logic           pop;

  always_comb begin
    popValid = (occupancy != {OCC_W{1'b0}});
    popData  = head;
    pop      = popValid && popReady;
  end

  // Simultaneous push and pop keep occupancy and shift the tail forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= {LEN{1'b0}};
      tail      <= {LEN{1'b0}};
      occupancy <= {OCC_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == {OCC_W{1'b0}}) begin
            head      <= pushData;
            occupancy <= occupancy + OCC_W'(1);
          end else if (occupancy == OCC_W'(1)) begin
            tail      <= pushData;
            occupancy <= occupancy + OCC_W'(1);
          end
        end
        2'b01: begin
          head      <= tail;
          occupancy <= occupancy - OCC_W'(1);
        end
        2'b11: begin
          if (occupancy == OCC_W'(1)) begin
            head <= pushData;
          end else begin
            head <= tail;
            tail <= pushData;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_stream_reader.sv
// Burst read sequencer: reads `count` bank entries from baseAddr and streams
// them out on valid/ready. Optional feature macro: READER_STALL_CNT_EN.
module reg_stream_reader
  import reg_reader_pkg::*;
#(
  parameter int LEN      = 9,
  parameter int ADDR_LEN = 4,
  parameter int CNT_LEN  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] baseAddr,
  input  logic [CNT_LEN-1:0]  count,
  output logic                busy,
  output logic                done,
  output logic                rdEn,
  output logic [ADDR_LEN-1:0] rdAddr,
  input  logic [LEN-1:0]      rdData,
  output logic [LEN-1:0]      dataOut,
  output logic                dataValid,
  input  logic                dataReady
`ifdef READER_STALL_CNT_EN
  ,
  output logic [15:0]         stallCnt
`endif
);

  state_t              state;
  logic [ADDR_LEN-1:0] addr;
  logic [CNT_LEN-1:0]  remaining;
  logic                in_flight;
  logic                done_idle;
  logic [OCC_W-1:0]    occupancy;
  logic [OCC_W:0]      pending;
  logic                pop_fire;
  logic                room;
  logic                last_pop;

  reg_skid_buf #(.LEN(LEN)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight),
    .pushData  (rdData),
    .popValid  (dataValid),
    .popData   (dataOut),
    .popReady  (dataReady),
    .occupancy (occupancy)
  );

  // A pop this cycle frees a slot for the word the next read will return.
  always_comb begin
    pop_fire = dataValid && dataReady;
    pending  = {1'b0, occupancy} + {{OCC_W{1'b0}}, in_flight};
    room     = (pending < (OCC_W+1)'(BUF_DEPTH)) ||
               ((pending == (OCC_W+1)'(BUF_DEPTH)) && pop_fire);
    rdEn     = (state == S_READ) && (remaining != {CNT_LEN{1'b0}}) && room;
    last_pop = (state == S_DRAIN) && pop_fire && (pending == (OCC_W+1)'(1));
    done     = done_idle || last_pop;
    busy     = (state != S_IDLE) && !last_pop;
    rdAddr   = addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= {ADDR_LEN{1'b0}};
      remaining <= {CNT_LEN{1'b0}};
      in_flight <= 1'b0;
      done_idle <= 1'b0;
    end else begin
      in_flight <= rdEn;
      done_idle <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= baseAddr;
            remaining <= count;
            if (count == {CNT_LEN{1'b0}}) begin
              done_idle <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (rdEn) begin
            addr      <= addr + ADDR_LEN'(1);
            remaining <= remaining - CNT_LEN'(1);
            if (remaining == CNT_LEN'(1)) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef READER_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= 16'd0;
    end else if ((state == S_IDLE) && start) begin
      stallCnt <= 16'd0;
    end else if (dataValid && !dataReady) begin
      stallCnt <= sat_inc16(stallCnt);
    end
  end
`endif

endmodule

// File: tb/tb_reg_stream_reader.sv
// Directed bench for reg_stream_reader: a bank model, a queue-based stream
// model with a per-cycle checker, and literal per-scenario expectations.
module tb_reg_stream_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] baseAddr;
  logic [4:0] count;
  logic       busy, done, rdEn;
  logic [3:0] rdAddr;
  logic [8:0] rdData;
  logic [8:0] dataOut;
  logic       dataValid;
  logic       dataReady;
`ifdef READER_STALL_CNT_EN
  logic [15:0] stallCnt;
`endif

  reg_stream_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .baseAddr  (baseAddr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .rdEn      (rdEn),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .dataReady (dataReady)
`ifdef READER_STALL_CNT_EN
    ,
    .stallCnt  (stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] bank [0:15];
  always @(posedge clk) if (rdEn) rdData <= bank[rdAddr];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Stream model: the addresses and words the current burst must produce.
  int         exp_addr_q[$];
  int         exp_data_q[$];
  int         issued = 0;
  int         accepted = 0;
  int         done_seen = 0;
  logic       prev_hold = 1'b0;
  logic [8:0] prev_dout = 9'd0;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", dataValid, 1);
        check("hold_data", dataOut, prev_dout);
      end
      if (rdEn) begin
        check("rden_expected", int'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("rd_addr", rdAddr, exp_addr_q.pop_front());
        issued++;
      end
      if (dataValid && dataReady) begin
        check("data_expected", int'(exp_data_q.size() > 0), 1);
        if (exp_data_q.size() > 0) check("data_out", dataOut, exp_data_q.pop_front());
        accepted++;
      end
      if (rdEn) check("outstanding_le2", int'((issued - accepted) <= 2), 1);
      if (done) begin
        check("done_all_delivered", exp_data_q.size(), 0);
        check("busy_low_at_done", busy, 0);
        done_seen++;
      end
      prev_hold = dataValid && !dataReady;
      prev_dout = dataOut;
    end
  end

  logic       rec_rden  [0:63];
  logic [3:0] rec_addr  [0:63];
  logic       rec_valid [0:63];
  logic [8:0] rec_dout  [0:63];
  logic       rec_busy  [0:63];
  logic [63:0] stall_mask;
  int          done_cyc;

  task automatic expect_burst(input logic [3:0] b, input logic [4:0] c);
    for (int i = 0; i < int'(c); i++) begin
      exp_addr_q.push_back((int'(b) + i) % 16);
      exp_data_q.push_back(int'(bank[(int'(b) + i) % 16]));
    end
  endtask

  // Start sampled at edge 0; cycle k is the interval after edge k-1.
  task automatic burst(input logic [3:0] b, input logic [4:0] c, input int restart_cyc);
    @(negedge clk);
    baseAddr = b; count = c; start = 1'b1; dataReady = 1'b1;
    expect_burst(b, c);
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    for (int k = 1; k < 60; k++) begin
      dataReady = !stall_mask[k];
      if (k == restart_cyc) begin
        start = 1'b1; baseAddr = 4'd7; count = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      rec_rden[k] = rdEn; rec_addr[k] = rdAddr; rec_valid[k] = dataValid;
      rec_dout[k] = dataOut; rec_busy[k] = busy;
      if (done) begin
        done_cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; dataReady = 1'b1;
    if (done_cyc < 0) check("burst_timeout", 0, 1);
  endtask

  int seen;

  initial begin
    reset = 1'b1; start = 1'b0; baseAddr = 4'd0; count = 5'd0; dataReady = 1'b1;
    stall_mask = 64'd0;
    for (int i = 0; i < 16; i++) bank[i] = 9'(i) + 9'h010;
    repeat (2) @(posedge clk); #1;
    check("rst_rden", rdEn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", dataValid, 0);
    check("rst_dout", dataOut, 0);
    check("rst_addr", rdAddr, 0);
    reset = 1'b0;

    burst(4'd0, 5'd4, -1);
    check("s1_done_cyc", done_cyc, 6);
    check("s1_rden_c1", rec_rden[1], 1);
    check("s1_addr_c1", rec_addr[1], 0);
    check("s1_addr_c4", rec_addr[4], 3);
    check("s1_rden_c5", rec_rden[5], 0);
    check("s1_valid_c2", rec_valid[2], 0);
    check("s1_dout_c3", rec_dout[3], 9'h010);
    check("s1_dout_c6", rec_dout[6], 9'h013);
    check("s1_busy_c1", rec_busy[1], 1);
    check("s1_busy_c6", rec_busy[6], 0);

    burst(4'd14, 5'd4, -1);
    check("wrap_addr_c3", rec_addr[3], 0);
    check("wrap_dout_c3", rec_dout[3], 9'h01E);
    check("wrap_dout_c5", rec_dout[5], 9'h010);

    burst(4'd3, 5'd0, -1);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_rden_c1", rec_rden[1], 0);
    check("zero_valid_c1", rec_valid[1], 0);
    check("zero_busy_c1", rec_busy[1], 0);

    stall_mask = 64'h0000_0000_0000_00F8;
    burst(4'd3, 5'd8, -1);
    stall_mask = 64'd0;
    check("stall_done_cyc", done_cyc, 15);
    check("stall_dout_c3", rec_dout[3], 9'h013);
    check("stall_dout_c7", rec_dout[7], 9'h013);
    check("stall_valid_c7", rec_valid[7], 1);
    check("stall_rden_c5", rec_rden[5], 0);
    check("stall_rden_c8", rec_rden[8], 1);
`ifdef READER_STALL_CNT_EN
    check("stall_cnt", stallCnt, 5);
`endif

    burst(4'd1, 5'd4, 2);
    check("restart_done_cyc", done_cyc, 6);
    check("restart_addr_c3", rec_addr[3], 3);
    check("restart_dout_c6", rec_dout[6], 9'h014);
    repeat (4) @(negedge clk);
    check("restart_idle_busy", busy, 0);

    @(negedge clk);
    baseAddr = 4'd2; count = 5'd8; start = 1'b1;
    expect_burst(4'd2, 5'd8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_rden", rdEn, 0);
    check("abort_addr", rdAddr, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", dataValid, 0);
    check("abort_dout", dataOut, 0);
    exp_addr_q.delete(); exp_data_q.delete();
    issued = 0; accepted = 0;
    seen = done_seen;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_seen, seen);

    burst(4'd5, 5'd3, -1);
    check("post_rst_done_cyc", done_cyc, 5);
    check("post_rst_dout_c3", rec_dout[3], 9'h015);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
